tlul_master: RTL and testbench

- Single-outstanding TileLink-UL (TL-UL) master that converts a simple byte-wide command port into A-channel requests and returns D-channel results.
- Writes use PutFullData; reads use Get.
- Sits between local control logic (CPU/sequencer glue) and a TL-UL crossbar or device port.
- 32-bit TL-UL data bus; byte-granular accesses only.

---
 rtl/tlul_pkg.sv | 29 ++
 rtl/tlul_master.sv | 152 +++++++++++++++
 tb/tb_tlul_master.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for tlul_master: opcodes, FSM states, bus widths
// and the byte-lane mask helper.
package tlul_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   // A-channel opcodes
   localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] GET              = 3'd4;

   // D-channel opcodes
   localparam logic [2:0] ACCESS_ACK       = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      A_REQ  = 2'd1,
      D_WAIT = 2'd2,
      RSP    = 2'd3
   } state_e;

   // One-hot byte-lane mask for a byte access at the given lane.
   function automatic logic [MASK_W-1:0] byte_mask(input logic [1:0] lane);
      return MASK_W'(1) << lane;
   endfunction

endpackage

// File: rtl/tlul_master.sv
// Single-outstanding TL-UL master: turns a byte-wide command port into one
// PutFullData/Get on the A channel and reports the D-channel result.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready    command port (write flag, byte address, write byte)
//   o_data                 last read byte
//   o_rsp_valid/o_rsp_error one-cycle completion pulse and sticky error
//   o_a_*/i_a_ready        TL-UL A channel
//   i_d_*/o_d_ready        TL-UL D channel
// Optional: define TLUL_MASTER_TIMEOUT_EN to abort D_WAIT with an error after
// TIMEOUT_CYCLES cycles without a matching D beat.
module tlul_master
   import tlul_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned SOURCE_W       = 4,
   parameter int unsigned SOURCE_ID      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic                i_cmd_write,
   input  logic [ADDR_W-1:0]   i_cmd_addr,
   input  logic [7:0]          i_data,
   output logic [7:0]          o_data,
   output logic                o_rsp_valid,
   output logic                o_rsp_error,
   output logic                o_a_valid,
   input  logic                i_a_ready,
   output logic [2:0]          o_a_opcode,
   output logic [2:0]          o_a_param,
   output logic [1:0]          o_a_size,
   output logic [SOURCE_W-1:0] o_a_source,
   output logic [ADDR_W-1:0]   o_a_address,
   output logic [MASK_W-1:0]   o_a_mask,
   output logic [DATA_W-1:0]   o_a_data,
   input  logic                i_d_valid,
   output logic                o_d_ready,
   input  logic [2:0]          i_d_opcode,
   input  logic [SOURCE_W-1:0] i_d_source,
   input  logic [DATA_W-1:0]   i_d_data,
   input  logic                i_d_error
);

   state_e      state_q;
   logic        write_q;
   logic [1:0]  lane_q;

   logic        d_hit_c;
   logic [2:0]  exp_op_c;

   // Only beats carrying our source ID belong to the outstanding request.
   assign d_hit_c  = i_d_valid && (i_d_source == SOURCE_W'(SOURCE_ID));
   assign exp_op_c = write_q ? ACCESS_ACK : ACCESS_ACK_DATA;

`ifdef TLUL_MASTER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit_c;
   assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   // Transaction FSM with registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         lane_q      <= 2'd0;
         o_cmd_ready <= 1'b1;
         o_d_ready   <= 1'b1;
         o_data      <= 8'h00;
         o_rsp_valid <= 1'b0;
         o_rsp_error <= 1'b0;
         o_a_valid   <= 1'b0;
         o_a_opcode  <= 3'd0;
         o_a_param   <= 3'd0;
         o_a_size    <= 2'd0;
         o_a_source  <= '0;
         o_a_address <= '0;
         o_a_mask    <= '0;
         o_a_data    <= '0;
`ifdef TLUL_MASTER_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         o_rsp_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               // Stray D beats are absorbed here because o_d_ready stays high.
               if (i_cmd_valid) begin
                  write_q     <= i_cmd_write;
                  lane_q      <= i_cmd_addr[1:0];
                  o_a_valid   <= 1'b1;
                  o_a_opcode  <= i_cmd_write ? PUT_FULL_DATA : GET;
                  o_a_param   <= 3'd0;
                  o_a_size    <= 2'd0;
                  o_a_source  <= SOURCE_W'(SOURCE_ID);
                  o_a_address <= i_cmd_addr;
                  o_a_mask    <= byte_mask(i_cmd_addr[1:0]);
                  o_a_data    <= i_cmd_write ? {4{i_data}} : '0;
                  o_cmd_ready <= 1'b0;
                  o_d_ready   <= 1'b0;
                  state_q     <= A_REQ;
               end
            end
            A_REQ: begin
               // D is not ready yet, so a same-cycle response must be held.
               if (i_a_ready) begin
                  o_a_valid <= 1'b0;
                  o_d_ready <= 1'b1;
                  state_q   <= D_WAIT;
`ifdef TLUL_MASTER_TIMEOUT_EN
                  tmo_q     <= '0;
`endif
               end
            end
            D_WAIT: begin
               if (d_hit_c) begin
                  o_rsp_error <= i_d_error || (i_d_opcode != exp_op_c);
                  if (!write_q && (i_d_opcode == ACCESS_ACK_DATA))
                     o_data <= i_d_data[{lane_q, 3'b000} +: 8];
                  o_rsp_valid <= 1'b1;
                  o_d_ready   <= 1'b0;
                  state_q     <= RSP;
               end
`ifdef TLUL_MASTER_TIMEOUT_EN
               else if (tmo_hit_c) begin
                  o_rsp_error <= 1'b1;
                  o_rsp_valid <= 1'b1;
                  o_d_ready   <= 1'b0;
                  state_q     <= RSP;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
`endif
            end
            RSP: begin
               o_cmd_ready <= 1'b1;
               o_d_ready   <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlul_master.sv
// Self-checking bench for tlul_master with a response scoreboard.
module tb_tlul_master;
   import tlul_pkg::*;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned SOURCE_W  = 4;
   localparam int unsigned SOURCE_ID = 3;
   localparam int unsigned TMO       = 16;

   logic                i_clk, i_reset;
   logic                i_cmd_valid, o_cmd_ready, i_cmd_write;
   logic [ADDR_W-1:0]   i_cmd_addr;
   logic [7:0]          i_data, o_data;
   logic                o_rsp_valid, o_rsp_error;
   logic                o_a_valid, i_a_ready;
   logic [2:0]          o_a_opcode, o_a_param;
   logic [1:0]          o_a_size;
   logic [SOURCE_W-1:0] o_a_source;
   logic [ADDR_W-1:0]   o_a_address;
   logic [3:0]          o_a_mask;
   logic [31:0]         o_a_data;
   logic                i_d_valid, o_d_ready;
   logic [2:0]          i_d_opcode;
   logic [SOURCE_W-1:0] i_d_source;
   logic [31:0]         i_d_data;
   logic                i_d_error;

   tlul_master #(
      .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .SOURCE_ID(SOURCE_ID), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
      .i_cmd_addr(i_cmd_addr), .i_data(i_data), .o_data(o_data),
      .o_rsp_valid(o_rsp_valid), .o_rsp_error(o_rsp_error),
      .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode),
      .o_a_param(o_a_param), .o_a_size(o_a_size), .o_a_source(o_a_source),
      .o_a_address(o_a_address), .o_a_mask(o_a_mask), .o_a_data(o_a_data),
      .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode),
      .i_d_source(i_d_source), .i_d_data(i_d_data), .i_d_error(i_d_error)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   int         a_beats = 0;
   int         rsp_pulses = 0;
   logic [7:0] model_data;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_a_valid && i_a_ready) a_beats <= a_beats + 1;
      if (o_rsp_valid) rsp_pulses <= rsp_pulses + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] lane_of(input logic [31:0] d, input logic [1:0] l);
      return 8'(d >> (8 * l));
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drive one command for a cycle and record the response it should produce.
   task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [7:0] d,
                           input logic e_err, input logic [7:0] e_data);
      exp_t e;
      i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = addr; i_data = d;
      e.err = e_err; e.data = e_data;
      sb.push_back(e);
      tick();
      i_cmd_valid = 1'b0; i_data = 8'($urandom);
   endtask

   task automatic a_handshake(input int stall);
      i_a_ready = 1'b0;
      for (int i = 0; i < stall; i++) tick();
      i_a_ready = 1'b1;
      tick();
      i_a_ready = 1'b0;
   endtask

   task automatic d_beat(input logic [2:0] op, input logic [SOURCE_W-1:0] src,
                         input logic [31:0] d, input logic err);
      i_d_valid = 1'b1; i_d_opcode = op; i_d_source = src; i_d_data = d; i_d_error = err;
      tick();
      i_d_valid = 1'b0; i_d_data = $urandom;
   endtask

   // Wait (bounded) for the completion pulse and pop the matching expectation.
   task automatic pop_rsp(output bit found, output logic err, output logic [7:0] data,
                          output exp_t e);
      found = 1'b0; err = 1'bx; data = 8'hxx; e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      for (int i = 0; i < 64; i++) begin
         if (o_rsp_valid === 1'b1) begin
            found = 1'b1; err = o_rsp_error; data = o_data;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_data = 8'($urandom);
      tick();
      i_data = 8'($urandom);
      tick();
      total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", o_data); end
      total++; if (o_a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", o_a_valid); end
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
      total++; if ({o_rsp_valid, o_rsp_error, o_a_opcode, o_a_mask, o_a_data} !== '0) begin
         bad++; $display("FAIL reset_fields: rsp=%b err=%b op=%h mask=%h data=%h want all 0",
                         o_rsp_valid, o_rsp_error, o_a_opcode, o_a_mask, o_a_data); end
      i_reset = 1'b0;
      model_data = 8'h00;
   endtask

   task automatic test_write();
      bit found; logic err; logic [7:0] data; exp_t e;
      send_cmd(1'b1, 32'h102, 8'hA5, 1'b0, model_data);
      total++; if (o_a_valid !== 1'b1) begin bad++; $display("FAIL wr_a_valid: got %b want 1", o_a_valid); end
      total++; if (o_a_opcode !== 3'd0) begin bad++; $display("FAIL wr_opcode: got %h want 0", o_a_opcode); end
      total++; if (o_a_mask !== 4'b0100) begin bad++; $display("FAIL wr_mask: got %b want 0100", o_a_mask); end
      total++; if (o_a_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL wr_data: got %h want a5a5a5a5", o_a_data); end
      total++; if ({o_a_address, o_a_source, o_a_param, o_a_size} !== {32'h102, 4'(SOURCE_ID), 3'd0, 2'd0}) begin
         bad++; $display("FAIL wr_fields: addr=%h src=%h param=%h size=%h want 102/%h/0/0",
                         o_a_address, o_a_source, o_a_param, o_a_size, 4'(SOURCE_ID)); end
      total++; if ({o_d_ready, o_cmd_ready} !== 2'b00) begin bad++; $display("FAIL a_req_readies: got %b want 00", {o_d_ready, o_cmd_ready}); end
      a_handshake(0);
      d_beat(ACCESS_ACK, 4'(SOURCE_ID), 32'hDEADBEEF, 1'b0);
      total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL min_latency: rsp_valid got %b want 1", o_rsp_valid); end
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL wr_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      tick();
      total++; if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin bad++; $display("FAIL rsp_one_cycle: got %b want 01", {o_rsp_valid, o_cmd_ready}); end
   endtask

   task automatic test_read();
      bit found; logic err; logic [7:0] data; exp_t e;
      send_cmd(1'b0, 32'h103, 8'($urandom), 1'b0, 8'h5A);
      total++; if ({o_a_opcode, o_a_mask, o_a_data} !== {3'd4, 4'b1000, 32'h0}) begin
         bad++; $display("FAIL rd_a: op=%h mask=%b data=%h want 4/1000/0", o_a_opcode, o_a_mask, o_a_data); end
      a_handshake(0);
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h5A000000, 1'b0);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL rd_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      model_data = 8'h5A;
      tick();
      // Random lanes, stalls and D delays.
      for (int k = 0; k < 6; k++) begin
         logic [31:0] addr, dd;
         addr = $urandom; dd = $urandom;
         send_cmd(1'b0, addr, 8'($urandom), 1'b0, lane_of(dd, addr[1:0]));
         total++; if (o_a_mask !== byte_mask(addr[1:0]) || o_a_address !== addr) begin
            bad++; $display("FAIL rnd_a%0d: mask=%b addr=%h want mask for %h", k, o_a_mask, o_a_address, addr); end
         a_handshake(int'($urandom_range(0, 3)));
         for (int j = 0; j < int'($urandom_range(0, 4)); j++) tick();
         d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), dd, 1'b0);
         pop_rsp(found, err, data, e);
         total++; if (!found || {err, data} !== {e.err, e.data}) begin
            bad++; $display("FAIL rnd_rsp%0d: found=%b err=%b data=%h want err=%b data=%h", k, found, err, data, e.err, e.data); end
         model_data = e.data;
         tick();
      end
   endtask

   task automatic test_backpressure();
      bit found; logic err; logic [7:0] data; exp_t e;
      logic [75:0] snap;
      int beats0, unstable;
      beats0 = a_beats; unstable = 0;
      send_cmd(1'b1, 32'h44, 8'h3C, 1'b0, model_data);
      snap = {o_a_opcode, o_a_param, o_a_size, o_a_source, o_a_address, o_a_mask, o_a_data};
      total++; if (snap !== {3'd0, 3'd0, 2'd0, 4'(SOURCE_ID), 32'h44, 4'b0001, 32'h3C3C3C3C}) begin
         bad++; $display("FAIL bp_fields: got %h", snap); end
      i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h999; i_a_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_a_valid !== 1'b1 || o_cmd_ready !== 1'b0 ||
             {o_a_opcode, o_a_param, o_a_size, o_a_source, o_a_address, o_a_mask, o_a_data} !== snap)
            unstable++;
      end
      total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: unstable cycles got %0d want 0", unstable); end
      i_cmd_valid = 1'b0;
      a_handshake(0);
      d_beat(ACCESS_ACK, 4'(SOURCE_ID), 32'h0, 1'b0);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL bp_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      tick(); tick(); tick();
      total++; if (a_beats - beats0 != 1) begin bad++; $display("FAIL bp_beats: got %0d want 1", a_beats - beats0); end
   endtask

   task automatic test_d_error();
      bit found; logic err; logic [7:0] data; exp_t e;
      send_cmd(1'b0, 32'h10, 8'h00, 1'b1, 8'hC3);
      a_handshake(1);
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h000000C3, 1'b1);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL derr_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      model_data = 8'hC3;
      tick();
   endtask

   task automatic test_wrong_source();
      bit found; logic err; logic [7:0] data; exp_t e;
      int pulses0;
      pulses0 = rsp_pulses;
      send_cmd(1'b0, 32'h21, 8'h00, 1'b0, 8'h77);
      a_handshake(0);
      d_beat(ACCESS_ACK_DATA, 4'd5, 32'h0000EE00, 1'b1);
      total++; if ({o_rsp_valid, o_d_ready} !== 2'b01) begin
         bad++; $display("FAIL wsrc_ignored: rsp/d_ready got %b want 01", {o_rsp_valid, o_d_ready}); end
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h00007700, 1'b0);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL wsrc_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      model_data = 8'h77;
      tick(); tick(); tick();
      total++; if (rsp_pulses - pulses0 != 1) begin bad++; $display("FAIL wsrc_pulses: got %0d want 1", rsp_pulses - pulses0); end
   endtask

   task automatic test_opcode_mismatch();
      bit found; logic err; logic [7:0] data; exp_t e;
      send_cmd(1'b1, 32'h8, 8'h11, 1'b1, model_data);
      a_handshake(0);
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h22222222, 1'b0);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL opmis_wr: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      tick();
      send_cmd(1'b0, 32'h9, 8'h00, 1'b1, model_data);
      a_handshake(0);
      d_beat(ACCESS_ACK, 4'(SOURCE_ID), 32'h33333333, 1'b0);
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL opmis_rd: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      tick();
   endtask

   task automatic test_zero_latency();
      bit found; logic err; logic [7:0] data; exp_t e;
      send_cmd(1'b0, 32'h0, 8'h00, 1'b0, 8'hB7);
      i_a_ready = 1'b1;
      i_d_valid = 1'b1; i_d_opcode = ACCESS_ACK_DATA; i_d_source = 4'(SOURCE_ID);
      i_d_data = 32'h000000B7; i_d_error = 1'b0;
      tick();
      i_a_ready = 1'b0;
      total++; if ({o_rsp_valid, o_d_ready} !== 2'b01) begin
         bad++; $display("FAIL zlat_held: rsp/d_ready got %b want 01", {o_rsp_valid, o_d_ready}); end
      tick();
      i_d_valid = 1'b0;
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL zlat_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      model_data = 8'hB7;
      tick();
   endtask

   task automatic test_stray_d();
      int pulses0;
      pulses0 = rsp_pulses;
      total++; if (o_d_ready !== 1'b1) begin bad++; $display("FAIL idle_d_ready: got %b want 1", o_d_ready); end
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'hFFFFFFFF, 1'b1);
      tick();
      total++; if (rsp_pulses != pulses0 || o_data !== model_data || o_cmd_ready !== 1'b1) begin
         bad++; $display("FAIL stray_d: pulses=%0d data=%h ready=%b want %0d/%h/1",
                         rsp_pulses, o_data, o_cmd_ready, pulses0, model_data); end
   endtask

   task automatic test_reset_mid();
      int pulses0;
      send_cmd(1'b0, 32'h1, 8'h00, 1'b0, 8'h00);
      a_handshake(0);
      pulses0 = rsp_pulses;
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      void'(sb.pop_back());
      model_data = 8'h00;
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h0000AB00, 1'b0);
      tick();
      total++; if (rsp_pulses != pulses0 || {o_cmd_ready, o_a_valid} !== 2'b10 || o_data !== 8'h00) begin
         bad++; $display("FAIL reset_mid: pulses=%0d ready=%b a_valid=%b data=%h want %0d/1/0/00",
                         rsp_pulses, o_cmd_ready, o_a_valid, o_data, pulses0); end
   endtask

`ifdef TLUL_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      bit found; logic err; logic [7:0] data; exp_t e;
      int early;
      early = 0;
      send_cmd(1'b0, 32'h2, 8'h00, 1'b1, model_data);
      a_handshake(0);
      for (int i = 0; i < int'(TMO) - 1; i++) begin
         tick();
         if (o_rsp_valid !== 1'b0) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL tmo_early: pulses got %0d want 0", early); end
      tick();
      total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL tmo_edge: rsp_valid got %b want 1", o_rsp_valid); end
      pop_rsp(found, err, data, e);
      total++; if (!found || {err, data} !== {e.err, e.data}) begin
         bad++; $display("FAIL tmo_rsp: found=%b err=%b data=%h want err=%b data=%h", found, err, data, e.err, e.data); end
      tick();
      d_beat(ACCESS_ACK_DATA, 4'(SOURCE_ID), 32'h12345678, 1'b0);
      tick();
      total++; if ({o_rsp_valid, o_cmd_ready} !== 2'b01 || o_data !== model_data) begin
         bad++; $display("FAIL tmo_late: rsp=%b ready=%b data=%h want 0/1/%h", o_rsp_valid, o_cmd_ready, o_data, model_data); end
   endtask
`endif

   initial begin
      i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_data = '0;
      i_a_ready = 1'b0; i_d_valid = 1'b0; i_d_opcode = '0; i_d_source = '0;
      i_d_data = '0; i_d_error = 1'b0;
      model_data = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_d_error();
      test_wrong_source();
      test_opcode_mismatch();
      test_zero_latency();
      test_stray_d();
`ifdef TLUL_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
